// File: rtl/smem_bank_rr.sv
// Round-robin arbitrated shared-memory bank, 1-cycle tagged responses.
// Optional contention counter: define SMEM_CONFLICT_STATS_EN.
module smem_bank_rr #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_we,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [15:0]               busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  logic [ID_W-1:0]    r_ptr;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic               r_rsp_we;
  logic [DATA_W-1:0]  r_rsp_data;

  logic [NUM_REQ-1:0] w_gnt;
  logic               w_any;
  logic [ID_W-1:0]    w_idx;
  logic               w_we;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;
  logic [ID_W-1:0]    w_nxt;
  int                 w_k;

  // Scan from r_ptr upward, wrapping; first requester found wins.
  always_comb begin
    w_gnt   = '0;
    w_any   = 1'b0;
    w_idx   = '0;
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    w_k     = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_k = (int'(r_ptr) + j) % NUM_REQ;
      if (!reset && !w_any && req[w_k]) begin
        w_any      = 1'b1;
        w_idx      = ID_W'(w_k);
        w_gnt[w_k] = 1'b1;
        w_we       = req_we[w_k];
        w_addr     = req_addr[w_k*ADDR_W +: ADDR_W];
        w_wdata    = req_wdata[w_k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_nxt = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clock) begin
    if (w_any && w_we) begin
      r_mem[w_addr] <= w_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_we    <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_any;
      if (w_any) begin
        r_ptr      <= w_nxt;
        r_rsp_id   <= w_idx;
        r_rsp_we   <= w_we;
        r_rsp_data <= w_we ? w_wdata : r_mem[w_addr];
      end
    end
  end

`ifdef SMEM_CONFLICT_STATS_EN
  logic [15:0] r_busy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else if ($countones(req) >= 2 && r_busy != 16'hFFFF) begin
      r_busy <= r_busy + 16'd1;
    end
  end

  assign busy_cnt = r_busy;
`else
  assign busy_cnt = '0;
`endif

  assign gnt       = w_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_we    = r_rsp_we;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_smem_bank_rr.sv
// Directed vector bench for smem_bank_rr (default parameters).
// Busy counter expectations follow SMEM_CONFLICT_STATS_EN.
module tb_smem_bank_rr;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NR = 4;
  localparam int IW = 2;

  logic          clock;
  logic          reset;
  logic [NR-1:0] req;
  logic [NR-1:0] req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0] gnt;
  logic          rsp_valid;
  logic [IW-1:0] rsp_id;
  logic          rsp_we;
  logic [DW-1:0] rsp_data;
  logic [15:0]   busy_cnt;

  int n_cmp;
  int n_err;

  smem_bank_rr #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REQ(NR)
  ) dut (
    .clock(clock), .reset(reset),
    .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_we(rsp_we),
    .rsp_data(rsp_data), .busy_cnt(busy_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] rq;
    logic [3:0] we;
    logic [7:0] ad;
    logic [7:0] wd;
    logic [3:0] eg;
    logic       rv;
    logic [1:0] id;
    logic       rwe;
    logic [7:0] rd;
  } vec_t;

  vec_t tv [19];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] rq, input logic [3:0] we,
                       input logic [7:0] ad, input logic [7:0] wd);
    req       = rq;
    req_we    = we;
    req_addr  = {NR{ad}};
    req_wdata = {NR{wd}};
  endtask

  logic [15:0] exp_busy;

  initial begin
    n_cmp = 0;
    n_err = 0;
    // rq, we, addr, wdata | gnt, rsp_valid, id, we, data
    tv[0]  = '{4'b0001, 4'b1111, 8'h10, 8'hA5, 4'b0001, 1'b0, 2'd0, 1'b0, 8'h00};
    tv[1]  = '{4'b0100, 4'b1111, 8'hFF, 8'h3C, 4'b0100, 1'b1, 2'd0, 1'b1, 8'hA5};
    tv[2]  = '{4'b0100, 4'b0000, 8'hFF, 8'h00, 4'b0100, 1'b1, 2'd2, 1'b1, 8'h3C};
    tv[3]  = '{4'b0001, 4'b0000, 8'h10, 8'h00, 4'b0001, 1'b1, 2'd2, 1'b0, 8'h3C};
    tv[4]  = '{4'b0000, 4'b0000, 8'h10, 8'h00, 4'b0000, 1'b1, 2'd0, 1'b0, 8'hA5};
    tv[5]  = '{4'b0000, 4'b0000, 8'h10, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0, 8'hA5};
    tv[6]  = '{4'b1000, 4'b1000, 8'h20, 8'h77, 4'b1000, 1'b0, 2'd0, 1'b0, 8'hA5};
    tv[7]  = '{4'b1111, 4'b0000, 8'h20, 8'h00, 4'b0001, 1'b1, 2'd3, 1'b1, 8'h77};
    tv[8]  = '{4'b1111, 4'b0000, 8'h20, 8'h00, 4'b0010, 1'b1, 2'd0, 1'b0, 8'h77};
    tv[9]  = '{4'b1111, 4'b0000, 8'h20, 8'h00, 4'b0100, 1'b1, 2'd1, 1'b0, 8'h77};
    tv[10] = '{4'b1111, 4'b0000, 8'h20, 8'h00, 4'b1000, 1'b1, 2'd2, 1'b0, 8'h77};
    tv[11] = '{4'b1111, 4'b0000, 8'h20, 8'h00, 4'b0001, 1'b1, 2'd3, 1'b0, 8'h77};
    tv[12] = '{4'b1111, 4'b0000, 8'h20, 8'h00, 4'b0010, 1'b1, 2'd0, 1'b0, 8'h77};
    tv[13] = '{4'b1111, 4'b0000, 8'h20, 8'h00, 4'b0100, 1'b1, 2'd1, 1'b0, 8'h77};
    tv[14] = '{4'b1111, 4'b0000, 8'h20, 8'h00, 4'b1000, 1'b1, 2'd2, 1'b0, 8'h77};
    tv[15] = '{4'b1001, 4'b0000, 8'h10, 8'h00, 4'b0001, 1'b1, 2'd3, 1'b0, 8'h77};
    tv[16] = '{4'b1001, 4'b0000, 8'h10, 8'h00, 4'b1000, 1'b1, 2'd0, 1'b0, 8'hA5};
    tv[17] = '{4'b0000, 4'b0000, 8'h10, 8'h00, 4'b0000, 1'b1, 2'd3, 1'b0, 8'hA5};
    tv[18] = '{4'b0000, 4'b0000, 8'h10, 8'h00, 4'b0000, 1'b0, 2'd3, 1'b0, 8'hA5};

    reset = 1'b1;
    drive(4'b1111, 4'b0000, 8'h00, 8'h00);
    repeat (2) @(negedge clock);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rv", 32'(rsp_valid), 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);
    chk("rst_we", 32'(rsp_we), 32'h0);
    chk("rst_data", 32'(rsp_data), 32'h0);
    chk("rst_busy", 32'(busy_cnt), 32'h0);
    drive(4'b0000, 4'b0000, 8'h00, 8'h00);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clock);
      drive(tv[i].rq, tv[i].we, tv[i].ad, tv[i].wd);
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tv[i].eg));
      chk($sformatf("v%0d_rv", i), 32'(rsp_valid), 32'(tv[i].rv));
      chk($sformatf("v%0d_id", i), 32'(rsp_id), 32'(tv[i].id));
      chk($sformatf("v%0d_rwe", i), 32'(rsp_we), 32'(tv[i].rwe));
      chk($sformatf("v%0d_data", i), 32'(rsp_data), 32'(tv[i].rd));
    end

    // Async reset between a read's acceptance and its response.
    @(negedge clock);
    drive(4'b0010, 4'b0000, 8'hFF, 8'h00);
    #1;
    chk("ar_gnt", 32'(gnt), 32'b0010);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_rv_now", 32'(rsp_valid), 32'h0);
    chk("ar_gnt_rst", 32'(gnt), 32'h0);
    @(negedge clock);
    drive(4'b1001, 4'b0000, 8'h10, 8'h00);
    reset = 1'b0;
    #1;
    chk("ar_rv_after", 32'(rsp_valid), 32'h0);
    chk("ar_ptr0_gnt", 32'(gnt), 32'b0001);
    @(negedge clock);
    drive(4'b0100, 4'b0000, 8'hFF, 8'h00);
    #1;
    chk("ar_rd10_rv", 32'(rsp_valid), 32'h1);
    chk("ar_rd10_data", 32'(rsp_data), 32'hA5);
    chk("ar_rd10_id", 32'(rsp_id), 32'h0);
    @(negedge clock);
    drive(4'b0000, 4'b0000, 8'h00, 8'h00);
    #1;
    chk("ar_rdff_data", 32'(rsp_data), 32'h3C);
    chk("ar_rdff_id", 32'(rsp_id), 32'h2);

    // Contention counter.
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("bc_rst", 32'(busy_cnt), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    drive(4'b0110, 4'b0000, 8'h10, 8'h00);
    repeat (5) @(negedge clock);
`ifdef SMEM_CONFLICT_STATS_EN
    exp_busy = 16'd5;
`else
    exp_busy = 16'd0;
`endif
    #1;
    chk("bc_after5", 32'(busy_cnt), 32'(exp_busy));
    drive(4'b0100, 4'b0000, 8'h10, 8'h00);
    repeat (3) @(negedge clock);
    drive(4'b0000, 4'b0000, 8'h00, 8'h00);
    #1;
    chk("bc_final", 32'(busy_cnt), 32'(exp_busy));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
